// File: rtl/ram_master.sv
// ram_master: single-outstanding bus initiator for the synchronous ram block.
// Converts valid/ready read/write/clear requests into registered ram strobes,
// owns the shared tri-state data bus, and returns a held valid/ready response.
module ram_master #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic                  mem_reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_WR      = 3'd1;
  localparam logic [STATE_W-1:0] S_RD_ADDR = 3'd2;
  localparam logic [STATE_W-1:0] S_RD_DATA = 3'd3;
  localparam logic [STATE_W-1:0] S_CLR     = 3'd4;
  localparam logic [STATE_W-1:0] S_RESP    = 3'd5;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  logic [STATE_W-1:0]    state_q,      state_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic                  mem_en_q,     mem_en_d;
  logic                  mem_wr_q,     mem_wr_d;
  logic                  mem_reset_q,  mem_reset_d;
  logic                  drive_q,      drive_d;
  logic                  req_ready_q,  req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q,   resp_err_d;

  logic accept_c;

  // Request handshake; req_ready_q is high exactly when the FSM sits in IDLE.
  assign accept_c = req_valid & req_ready_q;

  // Next-state logic: one pass per op, RESP waits for the consumer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          unique case (req_op)
            OP_READ:  state_d = S_RD_ADDR;
            OP_WRITE: state_d = S_WR;
            OP_CLEAR: state_d = S_CLR;
            default:  state_d = S_RESP;
          endcase
        end
      end
      S_WR:      state_d = S_RESP;
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_RESP;
      S_CLR:     state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Request capture and response payload; payload is cleared on each new accept.
  always_comb begin
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    if (accept_c) begin
      wdata_d      = req_wdata;
      resp_rdata_d = DATA_WIDTH'(0);
      resp_err_d   = (req_op == 2'b11);
      if ((req_op == OP_READ) || (req_op == OP_WRITE)) begin
        mem_addr_d = req_addr;
      end
    end

    // Read data is stable on the bus through RD_DATA; sample at its closing edge.
    if (state_q == S_RD_DATA) begin
      resp_rdata_d = mem_data;
    end
  end

  // Bus strobes and handshake flags decoded from the upcoming state so they are registered.
  always_comb begin
    mem_en_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_reset_d  = 1'b0;
    drive_d      = 1'b0;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        req_ready_d = 1'b1;
      end
      S_WR: begin
        mem_en_d = 1'b1;
        mem_wr_d = 1'b1;
        drive_d  = 1'b1;
      end
      S_RD_ADDR, S_RD_DATA: begin
        mem_en_d = 1'b1;
      end
      S_CLR: begin
        mem_en_d    = 1'b1;
        mem_reset_d = 1'b1;
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
      end
      default: begin
        req_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wdata_q      <= DATA_WIDTH'(0);
      mem_addr_q   <= ADDR_WIDTH'(0);
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_reset_q  <= 1'b0;
      drive_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= DATA_WIDTH'(0);
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_reset_q  <= mem_reset_d;
      drive_q      <= drive_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Tri-state driver: the bus is only ours during WR; every WR follows IDLE, giving turnaround.
  assign mem_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_reset  = mem_reset_q;
  assign mem_addr   = mem_addr_q;

  // Structural invariants of the strobe encoding.
  a_wr_reset_excl : assert property (@(posedge clk) disable iff (reset) !(mem_wr_q && mem_reset_q));
  a_drive_is_wr   : assert property (@(posedge clk) disable iff (reset) (drive_q == mem_wr_q));
  a_en_not_resp   : assert property (@(posedge clk) disable iff (reset) !(mem_en_q && resp_valid_q));
  a_ready_idle    : assert property (@(posedge clk) disable iff (reset) (req_ready_q == (state_q == S_IDLE)));

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed stimulus with a response scoreboard for ram_master,
// including a behavioural synchronous ram on the shared bus.
module tb_ram_master;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_wr;
  logic          mem_reset;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_reset  (mem_reset),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural ram: drives the bus on enabled reads, writes/clears at the clock edge.
  logic [DW-1:0] ram [0:255];
  logic          ram_drive;
  assign ram_drive = mem_en && !mem_wr && !mem_reset;
  assign mem_data  = ram_drive ? ram[mem_addr[7:0]] : {DW{1'bz}};

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (mem_en && mem_wr) begin
      ram[mem_addr[7:0]] <= mem_data;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      check("resp_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  time last_acc_t = 0;

  task automatic wait_ready();
    int waitc;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
  endtask

  // Issue one op, check bus strobes, latency and optional backpressure; response goes to the scoreboard.
  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_en, input int hold, input int exp_gap);
    int  lat;
    int  en_cnt;
    time acc_t;
    exp_t e;
    wait_ready();
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    acc_t = $time;
    if (exp_gap != 0) check("issue_gap", 32'((acc_t - last_acc_t) / 10), 32'(exp_gap));
    last_acc_t = acc_t;
    #1;
    req_valid = 1'b0;
    req_op    = ~op;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    lat    = 0;
    en_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        en_cnt++;
        if (op == OP_WR) begin
          check("wr_mem_wr", 32'(mem_wr), 32'd1);
          check("wr_mem_reset", 32'(mem_reset), 32'd0);
          check("wr_mem_addr", 32'(mem_addr), 32'(addr));
          check("wr_mem_data", 32'(mem_data), 32'(wdata));
        end else if (op == OP_RD) begin
          check("rd_mem_wr", 32'(mem_wr), 32'd0);
          check("rd_mem_reset", 32'(mem_reset), 32'd0);
          check("rd_mem_addr", 32'(mem_addr), 32'(addr));
        end else if (op == OP_CLR) begin
          check("clr_mem_reset", 32'(mem_reset), 32'd1);
          check("clr_mem_wr", 32'(mem_wr), 32'd0);
        end
      end
    end while (!resp_valid && lat < 20);
    check("resp_latency", 32'(lat), 32'(exp_lat));
    check("mem_en_cycles", 32'(en_cnt), 32'(exp_en));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        check("hold_resp_valid", 32'(resp_valid), 32'd1);
        check("hold_req_ready", 32'(req_ready), 32'd0);
        check("hold_mem_en", 32'(mem_en), 32'd0);
        check("hold_rdata", 32'(resp_rdata), 32'(exp_rdata));
        check("hold_err", 32'(resp_err), 32'(exp_err));
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_reset", 32'(mem_reset), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //     op      addr      wdata     rdata     err   lat en hold gap
    do_op(OP_WR,  16'h000A, 16'h5A5A, 16'h0000, 1'b0, 2, 1, 0, 0);
    do_op(OP_RD,  16'h000A, 16'h0000, 16'h5A5A, 1'b0, 3, 2, 0, 3);
    do_op(OP_WR,  16'h0003, 16'h1234, 16'h0000, 1'b0, 2, 1, 0, 4);
    do_op(OP_WR,  16'h0004, 16'hBEEF, 16'h0000, 1'b0, 2, 1, 0, 3);
    do_op(OP_RD,  16'h0003, 16'h0000, 16'h1234, 1'b0, 3, 2, 0, 3);
    do_op(OP_RD,  16'h0004, 16'h0000, 16'hBEEF, 1'b0, 3, 2, 0, 4);
    do_op(OP_RD,  16'h0004, 16'h0000, 16'hBEEF, 1'b0, 3, 2, 5, 0);
    do_op(OP_WR,  16'h0005, 16'h00FF, 16'h0000, 1'b0, 2, 1, 0, 0);
    do_op(OP_CLR, 16'h0005, 16'h0000, 16'h0000, 1'b0, 2, 1, 0, 3);
    do_op(OP_RD,  16'h000A, 16'h0000, 16'h0000, 1'b0, 3, 2, 0, 3);
    do_op(OP_RD,  16'h0005, 16'h0000, 16'h0000, 1'b0, 3, 2, 0, 4);
    do_op(OP_WR,  16'h0007, 16'hA5C3, 16'h0000, 1'b0, 2, 1, 0, 4);
    do_op(OP_ILL, 16'h0007, 16'hFFFF, 16'h0000, 1'b1, 1, 0, 2, 0);
    do_op(OP_RD,  16'h0007, 16'h0000, 16'hA5C3, 1'b0, 3, 2, 0, 0);
    do_op(OP_ILL, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 4);
    do_op(OP_WR,  16'h0006, 16'h0F0F, 16'h0000, 1'b0, 2, 1, 0, 2);

    // Reset asserted while the read sits in RD_DATA: op aborts, no response.
    wait_ready();
    req_valid = 1'b1;
    req_op    = OP_RD;
    req_addr  = 16'h0006;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_rd_data_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_mem_en", 32'(mem_en), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;

    do_op(OP_WR,  16'h0008, 16'h1111, 16'h0000, 1'b0, 2, 1, 0, 0);
    do_op(OP_RD,  16'h0008, 16'h0000, 16'h1111, 1'b0, 3, 2, 0, 3);
    do_op(OP_RD,  16'h0006, 16'h0000, 16'h0F0F, 1'b0, 3, 2, 0, 4);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
